// File: rtl/bullet_collision_scanner.sv
// -----------------------------------------------------------------------------
// bullet_collision_scanner
//
// Once per frame, takes a snapshot of every player-bullet and enemy position
// and walks all bullet/enemy pairs, one pair per clock, testing axis-aligned
// box overlap. Each bullet and each enemy can take part in at most one hit
// per scan. The pairing is first come, first served in scan order (bullet
// major, enemy minor). At the end of the scan it emits a one-cycle report:
// the hit vectors the bullet and enemy controllers retire on, and a hit count
// for the score logic.
//
// Ports (all logic on the rising edge of clk25):
//   clk25              pixel clock
//   rst_n              synchronous active-low reset; aborts a scan in flight
//   frame_tick         scan request, accepted only while idle and not busy
//   bullet_x_flat      bullet i x coordinate at [i*10 +: 10]
//   bullet_y_flat      bullet i y coordinate at [i*10 +: 10]
//   bullet_active_flat bullet i live
//   enemy_x_flat       enemy j x coordinate at [j*10 +: 10]
//   enemy_y_flat       enemy j y coordinate at [j*10 +: 10]
//   enemy_active_flat  enemy j live
//   bullet_hit         report-cycle pulse, bit i = bullet i hit an enemy
//   enemy_hit          report-cycle pulse, bit j = enemy j was hit
//   hit_count          number of hit pairs, non-zero only in the report cycle
//   scan_done          one-cycle pulse marking the report cycle
//   busy               high from the cycle after acceptance through the report
// -----------------------------------------------------------------------------
module bullet_collision_scanner #(
  parameter int BULLET_COUNT = 8,
  parameter int ENEMY_COUNT  = 4,
  parameter int BULLET_W     = 4,
  parameter int BULLET_H     = 8,
  parameter int ENEMY_W      = 32,
  parameter int ENEMY_H      = 32
) (
  input  logic                                  clk25,
  input  logic                                  rst_n,
  input  logic                                  frame_tick,
  input  logic [10*BULLET_COUNT-1:0]            bullet_x_flat,
  input  logic [10*BULLET_COUNT-1:0]            bullet_y_flat,
  input  logic [BULLET_COUNT-1:0]               bullet_active_flat,
  input  logic [10*ENEMY_COUNT-1:0]             enemy_x_flat,
  input  logic [10*ENEMY_COUNT-1:0]             enemy_y_flat,
  input  logic [ENEMY_COUNT-1:0]                enemy_active_flat,
  output logic [BULLET_COUNT-1:0]               bullet_hit,
  output logic [ENEMY_COUNT-1:0]                enemy_hit,
  output logic [$clog2(BULLET_COUNT+1)-1:0]     hit_count,
  output logic                                  scan_done,
  output logic                                  busy
);

  localparam int CW  = $clog2(BULLET_COUNT + 1);
  localparam int BIW = (BULLET_COUNT > 1) ? $clog2(BULLET_COUNT) : 1;
  localparam int EIW = (ENEMY_COUNT > 1) ? $clog2(ENEMY_COUNT) : 1;

  localparam logic [BIW-1:0] B_LAST = BIW'(BULLET_COUNT - 1);
  localparam logic [EIW-1:0] E_LAST = EIW'(ENEMY_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    REPORT
  } state_t;

  state_t state, state_next;

  // Frame snapshot: the scan only ever looks at these, so bus activity
  // during a scan cannot disturb the result.
  logic [9:0]              snap_bx [BULLET_COUNT];
  logic [9:0]              snap_by [BULLET_COUNT];
  logic [BULLET_COUNT-1:0] snap_ba;
  logic [9:0]              snap_ex [ENEMY_COUNT];
  logic [9:0]              snap_ey [ENEMY_COUNT];
  logic [ENEMY_COUNT-1:0]  snap_ea;

  // Scan position and hit accumulators.
  logic [BIW-1:0]          b_idx;
  logic [EIW-1:0]          e_idx;
  logic [BULLET_COUNT-1:0] acc_b;
  logic [ENEMY_COUNT-1:0]  acc_e;
  logic [CW-1:0]           count;

  // ---------------------------------------------------------------------------
  // Pair evaluation for the current (b_idx, e_idx).
  // Coordinates are widened to 11 bits so that x+width near the right or
  // bottom of the 10-bit field cannot wrap and fake an overlap. Strict
  // comparisons mean boxes whose edges only touch do not collide.
  // ---------------------------------------------------------------------------
  logic [10:0] bx, by, ex, ey;
  logic        overlap;
  logic        pair_hit;
  logic        last_e;
  logic        last_pair;
  logic        start;

  assign bx = {1'b0, snap_bx[b_idx]};
  assign by = {1'b0, snap_by[b_idx]};
  assign ex = {1'b0, snap_ex[e_idx]};
  assign ey = {1'b0, snap_ey[e_idx]};

  assign overlap = (bx < ex + 11'(ENEMY_W))  &&
                   (bx + 11'(BULLET_W) > ex) &&
                   (by < ey + 11'(ENEMY_H))  &&
                   (by + 11'(BULLET_H) > ey);

  // A bullet or enemy already claimed this scan is out of play, which is
  // what makes the pairing one-to-one.
  assign pair_hit = snap_ba[b_idx] && snap_ea[e_idx] &&
                    !acc_b[b_idx]  && !acc_e[e_idx]  && overlap;

  assign last_e    = (e_idx == E_LAST);
  assign last_pair = last_e && (b_idx == B_LAST);

  // The registered busy output stays high for the report cycle, which is
  // spent back in IDLE; gating on it keeps a request made while the report
  // is still on the outputs from starting a new scan.
  assign start = (state == IDLE) && frame_tick && !busy;

  // ---------------------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next gets its default before the case so no path through
  // this block leaves it unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = SCAN;
      SCAN:    if (last_pair) state_next = REPORT;
      REPORT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Snapshot, scan datapath and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      // NOTE: the snapshot arrays are small flop banks rather than RAM, and
      // clearing them gives a defined state after reset at negligible cost.
      for (int i = 0; i < BULLET_COUNT; i++) begin
        snap_bx[i] <= '0;
        snap_by[i] <= '0;
      end
      for (int j = 0; j < ENEMY_COUNT; j++) begin
        snap_ex[j] <= '0;
        snap_ey[j] <= '0;
      end
      snap_ba <= '0;
      snap_ea <= '0;
      b_idx   <= '0;
      e_idx   <= '0;
      acc_b   <= '0;
      acc_e   <= '0;
      count   <= '0;
    end else if (start) begin
      for (int i = 0; i < BULLET_COUNT; i++) begin
        snap_bx[i] <= bullet_x_flat[i*10 +: 10];
        snap_by[i] <= bullet_y_flat[i*10 +: 10];
      end
      for (int j = 0; j < ENEMY_COUNT; j++) begin
        snap_ex[j] <= enemy_x_flat[j*10 +: 10];
        snap_ey[j] <= enemy_y_flat[j*10 +: 10];
      end
      snap_ba <= bullet_active_flat;
      snap_ea <= enemy_active_flat;
      b_idx   <= '0;
      e_idx   <= '0;
      acc_b   <= '0;
      acc_e   <= '0;
      count   <= '0;
    end else if (state == SCAN) begin
      if (pair_hit) begin
        acc_b[b_idx] <= 1'b1;
        acc_e[e_idx] <= 1'b1;
        count        <= count + CW'(1);
      end
      // Enemy index is the fast one; after the final pair both wrap to 0,
      // which is harmless since the next acceptance reloads them anyway.
      if (last_e) begin
        e_idx <= '0;
        b_idx <= last_pair ? '0 : b_idx + BIW'(1);
      end else begin
        e_idx <= e_idx + EIW'(1);
      end
    end
  end

  // Outputs are registered from the state, so the report appears the cycle
  // after REPORT and every pulse output is zero outside that cycle.
  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      bullet_hit <= '0;
      enemy_hit  <= '0;
      hit_count  <= '0;
      scan_done  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      busy      <= (state != IDLE);
      scan_done <= (state == REPORT);
      if (state == REPORT) begin
        bullet_hit <= acc_b;
        enemy_hit  <= acc_e;
        hit_count  <= count;
      end else begin
        bullet_hit <= '0;
        enemy_hit  <= '0;
        hit_count  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bullet_collision_scanner.sv
module tb_bullet_collision_scanner;

  localparam int NB = 8;
  localparam int NE = 4;
  localparam int N  = NB * NE;

  logic            clk25 = 1'b0;
  logic            rst_n;
  logic            frame_tick;
  logic [10*NB-1:0] bullet_x_flat, bullet_y_flat;
  logic [NB-1:0]    bullet_active_flat;
  logic [10*NE-1:0] enemy_x_flat, enemy_y_flat;
  logic [NE-1:0]    enemy_active_flat;
  logic [NB-1:0]    bullet_hit;
  logic [NE-1:0]    enemy_hit;
  logic [3:0]       hit_count;
  logic             scan_done;
  logic             busy;

  logic [9:0] bx [NB];
  logic [9:0] by [NB];
  logic [9:0] ex [NE];
  logic [9:0] ey [NE];

  int checks = 0;
  int errors = 0;

  always #20 clk25 = ~clk25;

  always_comb begin
    bullet_x_flat = '0;
    bullet_y_flat = '0;
    enemy_x_flat  = '0;
    enemy_y_flat  = '0;
    for (int i = 0; i < NB; i++) begin
      bullet_x_flat[i*10 +: 10] = bx[i];
      bullet_y_flat[i*10 +: 10] = by[i];
    end
    for (int j = 0; j < NE; j++) begin
      enemy_x_flat[j*10 +: 10] = ex[j];
      enemy_y_flat[j*10 +: 10] = ey[j];
    end
  end

  bullet_collision_scanner dut (
    .clk25              (clk25),
    .rst_n              (rst_n),
    .frame_tick         (frame_tick),
    .bullet_x_flat      (bullet_x_flat),
    .bullet_y_flat      (bullet_y_flat),
    .bullet_active_flat (bullet_active_flat),
    .enemy_x_flat       (enemy_x_flat),
    .enemy_y_flat       (enemy_y_flat),
    .enemy_active_flat  (enemy_active_flat),
    .bullet_hit         (bullet_hit),
    .enemy_hit          (enemy_hit),
    .hit_count          (hit_count),
    .scan_done          (scan_done),
    .busy               (busy)
  );

  task automatic tick();
    @(posedge clk25);
    #1;
  endtask

  task automatic clear_world();
    for (int i = 0; i < NB; i++) begin bx[i] = '0; by[i] = '0; end
    for (int j = 0; j < NE; j++) begin ex[j] = '0; ey[j] = '0; end
    bullet_active_flat = '0;
    enemy_active_flat  = '0;
  endtask

  // enemy0 at (100,50), bullet0 at (112,60), both live
  task automatic single_hit_world();
    clear_world();
    ex[0] = 10'd100; ey[0] = 10'd50; enemy_active_flat = 4'b0001;
    bx[0] = 10'd112; by[0] = 10'd60; bullet_active_flat = 8'h01;
  endtask

  // Pulses frame_tick and follows the scan to its report; lat = -1 if no
  // report arrives within the cycle budget.
  task automatic run_scan(output int lat, output logic busy_ok,
                          output logic [7:0] bh, output logic [3:0] eh,
                          output logic [3:0] hc, output logic quiet_after);
    lat = -1; busy_ok = 1'b1; bh = '0; eh = '0; hc = '0;
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    if (busy !== 1'b0) busy_ok = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (scan_done === 1'b1) begin
        lat = i; bh = bullet_hit; eh = enemy_hit; hc = hit_count;
        break;
      end
    end
    tick();
    quiet_after = (scan_done === 1'b0) && (busy === 1'b0) && (bullet_hit === '0) &&
                  (enemy_hit === '0) && (hit_count === '0);
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0; frame_tick = 1'b0;
    clear_world();
    tick(); tick(); tick();
    checks++;
    if ({bullet_hit, enemy_hit, hit_count, scan_done, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", {bullet_hit, enemy_hit, hit_count, scan_done, busy});
    end
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if ({bullet_hit, enemy_hit, hit_count, scan_done, busy} !== '0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL idle_quiet: %0d non-zero cycles, expected 0", bad); end
  endtask

  task automatic test_single_hit();
    int lat; logic bok, q; logic [7:0] bh; logic [3:0] eh, hc;
    single_hit_world();
    run_scan(lat, bok, bh, eh, hc, q);
    checks++; if (lat !== N + 1) begin errors++; $display("FAIL single_latency: got %0d expected %0d", lat, N + 1); end
    checks++; if (bh !== 8'h01) begin errors++; $display("FAIL single_bullet_hit: got %h expected 01", bh); end
    checks++; if (eh !== 4'h1) begin errors++; $display("FAIL single_enemy_hit: got %h expected 1", eh); end
    checks++; if (hc !== 4'd1) begin errors++; $display("FAIL single_hit_count: got %0d expected 1", hc); end
    checks++; if (bok !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", bok); end
    checks++; if (q !== 1'b1) begin errors++; $display("FAIL single_one_cycle: got %b expected 1", q); end
  endtask

  task automatic test_touching();
    int lat; logic bok, q; logic [7:0] bh; logic [3:0] eh, hc;
    // Right edge, bottom edge and top edge touches against enemy0.
    single_hit_world();
    bx[0] = 10'd132; by[0] = 10'd60;
    bx[1] = 10'd112; by[1] = 10'd82;
    bx[2] = 10'd112; by[2] = 10'd42;
    bullet_active_flat = 8'h07;
    run_scan(lat, bok, bh, eh, hc, q);
    checks++; if (lat !== N + 1) begin errors++; $display("FAIL touch_a_latency: got %0d expected %0d", lat, N + 1); end
    checks++; if ({bh, eh, hc} !== '0) begin errors++; $display("FAIL touch_a_hits: got %h/%h/%0d expected 0/0/0", bh, eh, hc); end
    // Left edge touch.
    single_hit_world();
    bx[0] = 10'd96;
    run_scan(lat, bok, bh, eh, hc, q);
    checks++; if (lat !== N + 1) begin errors++; $display("FAIL touch_b_latency: got %0d expected %0d", lat, N + 1); end
    checks++; if ({bh, hc} !== '0) begin errors++; $display("FAIL touch_b_hits: got %h/%0d expected 0/0", bh, hc); end
    // One pixel inside on each side: both overlap, only bullet0 gets enemy0.
    single_hit_world();
    bx[0] = 10'd131; bx[1] = 10'd97; by[1] = 10'd60;
    bullet_active_flat = 8'h03;
    run_scan(lat, bok, bh, eh, hc, q);
    checks++; if (bh !== 8'h01) begin errors++; $display("FAIL inside_bullet_hit: got %h expected 01", bh); end
    checks++; if (hc !== 4'd1) begin errors++; $display("FAIL inside_hit_count: got %0d expected 1", hc); end
  endtask

  task automatic test_priority();
    int lat; logic bok, q; logic [7:0] bh; logic [3:0] eh, hc;
    clear_world();
    ex[1] = 10'd200; ey[1] = 10'd100; enemy_active_flat = 4'b0010;
    bx[2] = 10'd210; by[2] = 10'd110;
    bx[3] = 10'd205; by[3] = 10'd100;
    bx[5] = 10'd215; by[5] = 10'd105;
    bullet_active_flat = 8'b0010_0100;
    run_scan(lat, bok, bh, eh, hc, q);
    checks++; if (bh !== 8'h04) begin errors++; $display("FAIL prio_bullet_hit: got %h expected 04", bh); end
    checks++; if (eh !== 4'h2) begin errors++; $display("FAIL prio_enemy_hit: got %h expected 2", eh); end
    checks++; if (hc !== 4'd1) begin errors++; $display("FAIL prio_hit_count: got %0d expected 1", hc); end
  endtask

  task automatic test_multi();
    int lat; logic bok, q; logic [7:0] bh; logic [3:0] eh, hc;
    // Two bullets each overlapping two adjacent enemies: one-to-one pairing.
    clear_world();
    ex[0] = 10'd100; ey[0] = 10'd50;
    ex[1] = 10'd120; ey[1] = 10'd50;
    enemy_active_flat = 4'b0011;
    bx[0] = 10'd125; by[0] = 10'd60;
    bx[1] = 10'd125; by[1] = 10'd60;
    bullet_active_flat = 8'h03;
    run_scan(lat, bok, bh, eh, hc, q);
    checks++; if (bh !== 8'h03) begin errors++; $display("FAIL multi_bullet_hit: got %h expected 03", bh); end
    checks++; if (eh !== 4'h3) begin errors++; $display("FAIL multi_enemy_hit: got %h expected 3", eh); end
    checks++; if (hc !== 4'd2) begin errors++; $display("FAIL multi_hit_count: got %0d expected 2", hc); end
  endtask

  task automatic test_snapshot();
    int lat, extra;
    logic [7:0] bh;
    single_hit_world();
    lat = -1; bh = '0;
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (i == 5) bx[0] = 10'd500;
      if (i == 9) frame_tick = 1'b1;
      if (i == 10) frame_tick = 1'b0;
      if (scan_done === 1'b1) begin lat = i; bh = bullet_hit; break; end
    end
    checks++; if (lat !== N + 1) begin errors++; $display("FAIL snap_latency: got %0d expected %0d", lat, N + 1); end
    checks++; if (bh !== 8'h01) begin errors++; $display("FAIL snap_bullet_hit: got %h expected 01", bh); end
    tick();
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy !== 1'b0 || scan_done !== 1'b0) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL snap_no_rescan: %0d busy cycles, expected 0", extra); end
  endtask

  task automatic test_back_to_back();
    int lat, extra; logic bok, q; logic [7:0] bh; logic [3:0] eh, hc;
    single_hit_world();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    for (int i = 1; i < N + 1; i++) tick();
    frame_tick = 1'b1;  // held across the REPORT->IDLE edge and the report cycle
    tick();
    checks++; if (scan_done !== 1'b1) begin errors++; $display("FAIL b2b_report: got %b expected 1", scan_done); end
    tick();
    frame_tick = 1'b0;
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy !== 1'b0 || scan_done !== 1'b0) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL b2b_ignored: %0d busy cycles, expected 0", extra); end
    run_scan(lat, bok, bh, eh, hc, q);
    checks++; if (lat !== N + 1) begin errors++; $display("FAIL b2b_next_latency: got %0d expected %0d", lat, N + 1); end
  endtask

  task automatic test_reset_mid_scan();
    int lat, extra; logic bok, q; logic [7:0] bh; logic [3:0] eh, hc;
    single_hit_world();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    for (int i = 1; i <= 20; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({bullet_hit, enemy_hit, hit_count, scan_done, busy} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h expected 0", {bullet_hit, enemy_hit, hit_count, scan_done, busy});
    end
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy !== 1'b0 || scan_done !== 1'b0) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL midreset_no_report: %0d busy cycles, expected 0", extra); end
    run_scan(lat, bok, bh, eh, hc, q);
    checks++; if (lat !== N + 1) begin errors++; $display("FAIL midreset_latency: got %0d expected %0d", lat, N + 1); end
    checks++; if (bh !== 8'h01) begin errors++; $display("FAIL midreset_bullet_hit: got %h expected 01", bh); end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_touching();
    test_priority();
    test_multi();
    test_snapshot();
    test_back_to_back();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bullet_collision_scanner.md
Name: bullet_collision_scanner

Overview:
Consumer of the player-bullet position/active buses and producer of the per-bullet hit vector those bullets are retired by. Once per frame it snapshots all bullet and enemy positions and scans every bullet/enemy pair sequentially, one pair per clock, using axis-aligned box overlap. It then reports bullet_hit and enemy_hit as single-cycle pulse vectors, plus a hit count for scoring. It sits between the bullet controller, the enemy controller and the score logic in the clk25 domain.

Parameters:
BULLET_COUNT, 8, number of bullet slots; matches the bullet bus width
ENEMY_COUNT, 4, number of enemy slots
BULLET_W, 4, bullet box width in pixels
BULLET_H, 8, bullet box height in pixels
ENEMY_W, 32, enemy box width in pixels
ENEMY_H, 32, enemy box height in pixels

Ports:
clk25  input  1  system pixel clock; all logic on its rising edge
rst_n  input  1  synchronous active-low reset
frame_tick  input  1  scan start request; sampled only in IDLE
bullet_x_flat  input  10*BULLET_COUNT  bullet i x at [i*10 +: 10]
bullet_y_flat  input  10*BULLET_COUNT  bullet i y at [i*10 +: 10]
bullet_active_flat  input  BULLET_COUNT  bullet i live
enemy_x_flat  input  10*ENEMY_COUNT  enemy j x at [j*10 +: 10]
enemy_y_flat  input  10*ENEMY_COUNT  enemy j y at [j*10 +: 10]
enemy_active_flat  input  ENEMY_COUNT  enemy j live
bullet_hit  output  BULLET_COUNT  one-cycle pulse; bit i set = bullet i hit something
enemy_hit  output  ENEMY_COUNT  one-cycle pulse; bit j set = enemy j was hit
hit_count  output  clog2(BULLET_COUNT+1)  number of hit pairs; valid while scan_done is high
scan_done  output  1  one-cycle pulse marking the report cycle
busy  output  1  high in SCAN and REPORT

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; indices, accumulators and snapshots cleared. bullet_hit, enemy_hit, hit_count, scan_done and busy all 0. Reset mid-scan aborts the scan with no report pulse.
- States: IDLE, SCAN, REPORT.
- IDLE: on an edge with frame_tick=1:
  - copy all six input buses into snapshot registers;
  - clear the hit accumulators (acc_b, acc_e, count);
  - set b=0, e=0 and go to SCAN.
- SCAN: each cycle, evaluate the snapshot pair (b,e). A hit requires all of:
  - bullet b active and enemy e active;
  - acc_b[b]=0 and acc_e[e]=0;
  - overlap: bx < ex+ENEMY_W, bx+BULLET_W > ex, by < ey+ENEMY_H, by+BULLET_H > ey.
- Overlap arithmetic is 11-bit unsigned (zero-extend, no wrap). Edges that only touch do not overlap.
- On a hit, set acc_b[b], acc_e[e] and count+1.
- Index advance: e increments; when e=ENEMY_COUNT-1, e wraps to 0 and b increments. After pair (BULLET_COUNT-1, ENEMY_COUNT-1) go to REPORT. SCAN lasts exactly N=BULLET_COUNT*ENEMY_COUNT cycles.
- Pairing is one-to-one per scan. A bullet retires on the first live overlapping enemy in scan order. An enemy absorbs only the lowest-index overlapping bullet; later bullets overlapping that enemy are not hit and keep flying.
- REPORT: lasts one cycle. bullet_hit=acc_b, enemy_hit=acc_e, hit_count=count and scan_done=1. Next state is IDLE, where all pulse outputs return to 0.
- Latency: frame_tick sampled at edge k -> outputs valid in the cycle following edge k+N+1. busy is high from edge k+1 through the REPORT cycle.
- frame_tick while busy is ignored, not queued. A frame_tick coincident with the REPORT->IDLE edge is also ignored.
- Input changes during SCAN have no effect; only the snapshot is used.
- Outside REPORT, bullet_hit, enemy_hit and hit_count are 0.

Test Plan:
- Reset then idle, frame_tick=0 -> all outputs 0, busy=0 indefinitely.
- Enemy0 at (100,50), bullet0 at (112,60), both active, frame_tick pulse -> after N+1=33 cycles: bullet_hit=8'h01, enemy_hit=4'h1, hit_count=1, scan_done=1 for exactly one cycle.
- Touching edges: bullet at x=132 (=ex+ENEMY_W), and separately at x=96 (bx+BULLET_W=100), both with y=60 -> bullet_hit=0, hit_count=0, scan_done still pulses.
- Bullets 2 and 5 both overlap enemy1; bullet 3 overlaps enemy1 but is inactive -> bullet_hit=8'h04, enemy_hit=4'h2, hit_count=1.
- Move bullet0 away at cycle 5 of SCAN and pulse frame_tick at cycle 10 -> report is unchanged from the snapshot (hit still reported), and no second scan starts.
- Drop rst_n at SCAN cycle 20 for one edge -> no scan_done pulse, busy=0, all outputs 0. A new frame_tick then completes a normal scan.
